// File: rtl/irq_pending_ctrl.sv
// Interrupt-request front end: synchronises N raw request lines, latches rising
// edges into per-source pending bits, masks them, and presents the lowest-index
// candidate through a valid/ack handshake. Ack clears the presented pending bit.
module irq_pending_ctrl #(
  parameter int unsigned N      = 8,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      irq_in,
  input  logic [N-1:0]      mask,
  input  logic              irq_ack,
  output logic              irq_valid,
  output logic [CODE_W-1:0] irq_code,
  output logic [N-1:0]      pending,
  output logic              dropped
);

  localparam logic StIdle    = 1'b0;
  localparam logic StPresent = 1'b1;

  logic [N-1:0]      s1_q, s2_q, s3_q;
  logic [N-1:0]      pending_q, pending_d;
  logic              dropped_q, dropped_d;
  logic              state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [N-1:0]      rise;
  logic [N-1:0]      clr;
  logic [N-1:0]      cand;
  logic              cand_any;
  logic [CODE_W-1:0] cand_idx;

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge detect, ack-driven clear and the pending/dropped next state; set wins over clear.
  always_comb begin
    rise      = s2_q & ~s3_q;
    clr       = '0;
    if (state_q == StPresent && irq_ack) begin
      clr[code_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | rise;
    dropped_d = |(rise & pending_q & ~clr);
  end

  // Priority pick over unmasked pending bits: lowest index wins.
  always_comb begin
    cand     = pending_q & ~mask;
    cand_any = |cand;
    cand_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_idx = CODE_W'(i);
      end
    end
  end

  // Handshake FSM: the code is captured on grant and frozen until ack.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (cand_any) begin
          code_d  = cand_idx;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (irq_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, code, pending and dropped registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      code_q    <= '0;
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign irq_valid = (state_q == StPresent);
  assign irq_code  = code_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic [7:0] mask = '0;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic [7:0] pending;
  logic       dropped;

  int n_cmp = 0;
  int n_err = 0;

  irq_pending_ctrl #(.N(8), .CODE_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .pending   (pending),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled lines, pending set, current grant.
  logic [7:0] m_h1, m_h2, m_h3;
  logic [7:0] m_pend;
  logic       m_drop;
  logic       m_valid;
  int         m_code;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] ev;
    logic [7:0] cl;
    logic [7:0] cand;
    int         pick;
    if (!rst_n) begin
      m_h1 <= '0; m_h2 <= '0; m_h3 <= '0;
      m_pend <= '0; m_drop <= 1'b0; m_valid <= 1'b0; m_code <= 0;
    end else begin
      // An event is a line seen high two samples ago and low three samples ago.
      ev = m_h2 & ~m_h3;
      cl = '0;
      if (m_valid && irq_ack) cl = 8'(1 << m_code);
      m_pend <= (m_pend & ~cl) | ev;
      m_drop <= |(ev & m_pend & ~cl);
      if (!m_valid) begin
        cand = m_pend & ~mask;
        pick = -1;
        for (int i = 0; i < 8; i++) if (pick < 0 && cand[i]) pick = i;
        if (pick >= 0) begin
          m_valid <= 1'b1;
          m_code  <= pick;
        end
      end else if (irq_ack) begin
        m_valid <= 1'b0;
      end
      m_h3 <= m_h2; m_h2 <= m_h1; m_h1 <= irq_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("valid", 32'(irq_valid), 32'(m_valid));
    if (m_valid) check("code", 32'(irq_code), 32'(m_code));
    check("pending", 32'(pending), 32'(m_pend));
    check("dropped", 32'(dropped), 32'(m_drop));
  endtask

  // Advance one clock and compare against the model on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_valid", 32'(irq_valid), 32'h0);
    check("rst_code", 32'(irq_code), 32'h0);
    check("rst_dropped", 32'(dropped), 32'h0);

    // Latency: line 5 sampled at edge k -> pending at k+2, valid at k+3.
    irq_in = 8'h20;
    ticks(2);
    check("lat_pend_k1", 32'(pending), 32'h00);
    tick();
    check("lat_pend_k2", 32'(pending), 32'h20);
    check("lat_valid_k2", 32'(irq_valid), 32'h0);
    tick();
    check("lat_valid_k3", 32'(irq_valid), 32'h1);
    check("lat_code_k3", 32'(irq_code), 32'h5);
    ack_once();
    check("lat_cleared", 32'(pending), 32'h00);
    irq_in = 8'h00;
    ticks(3);

    // Priority: 6 and 2 together -> 2 first, then 6.
    irq_in = 8'h44;
    ticks(4);
    check("prio_first", 32'(irq_code), 32'h2);
    ack_once();
    tick();
    check("prio_second_valid", 32'(irq_valid), 32'h1);
    check("prio_second", 32'(irq_code), 32'h6);
    ack_once();
    tick();
    check("prio_done_pend", 32'(pending), 32'h00);
    check("prio_done_valid", 32'(irq_valid), 32'h0);
    irq_in = 8'h00;
    ticks(3);

    // Mask: pending 0x09 with bit 0 masked -> 3, then 0 once unmasked.
    mask = 8'h01;
    irq_in = 8'h09;
    ticks(4);
    check("mask_pend", 32'(pending), 32'h09);
    check("mask_code", 32'(irq_code), 32'h3);
    ack_once();
    mask = 8'h00;
    tick();
    check("unmask_code", 32'(irq_code), 32'h0);
    check("unmask_valid", 32'(irq_valid), 32'h1);
    ack_once();
    irq_in = 8'h00;
    ticks(3);

    // Stability: 1 rises while 4 is presented; code stays 4 until ack.
    irq_in = 8'h10;
    ticks(4);
    irq_in = 8'h12;
    ticks(4);
    check("stable_code", 32'(irq_code), 32'h4);
    ack_once();
    tick();
    check("after_stable", 32'(irq_code), 32'h1);
    ack_once();
    irq_in = 8'h00;
    ticks(3);

    // Drop: second edge on 7 while still pending.
    irq_in = 8'h80;
    ticks(4);
    irq_in = 8'h00;
    ticks(3);
    irq_in = 8'h80;
    ticks(3);
    check("drop_pulse", 32'(dropped), 32'h1);
    check("drop_pend7", 32'(pending[7]), 32'h1);
    tick();
    check("drop_one_cycle", 32'(dropped), 32'h0);
    irq_in = 8'h00;
    ticks(3);
    // Edge on 7 lands in the same cycle as its ack: set wins, no drop.
    irq_in = 8'h80;
    ticks(2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("overlap_pend7", 32'(pending[7]), 32'h1);
    check("overlap_nodrop", 32'(dropped), 32'h0);
    tick();
    ack_once();
    tick();

    // Async reset mid-cycle while presenting, line 4 held high through it.
    irq_in = 8'h10;
    ticks(4);
    check("pre_rst_valid", 32'(irq_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(irq_valid), 32'h0);
    check("async_pend", 32'(pending), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    check("post_rst_event", 32'(pending), 32'h10);
    ticks(3);
    ack_once();
    ticks(3);
    check("post_rst_once", 32'(pending), 32'h00);

    // Randomized traffic with sparse edges, random mask and ack.
    for (int c = 0; c < 600; c++) begin
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    // Ack held continuously drains everything unmasked.
    mask = 8'h00;
    irq_ack = 1'b1;
    for (int c = 0; c < 200; c++) begin
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom & $urandom);
      tick();
    end
    irq_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt-request front end for 8 raw request lines.
- Synchronises each line, detects rising edges and holds one pending bit per source.
- Masks pending bits, then selects the highest-priority source: lowest index wins, bit 0 highest.
- Presents the winner's binary index to the downstream consumer through a valid/ack handshake and clears the pending bit on acknowledge.

Parameters:
- N, 8, number of request sources.
- CODE_W, 3, index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous assert, active-low.
- irq_in  input  N  raw request lines, asynchronous to clk; a rising edge is one event.
- mask  input  N  1 = source blocked from selection; its pending bit still sets.
- irq_ack  input  1  consumer accepts the presented code.
- irq_valid  output  1  irq_code holds a valid, stable index.
- irq_code  output  CODE_W  binary index of the selected source.
- pending  output  N  current pending register, unmasked.
- dropped  output  1  one-cycle pulse: an edge hit a source that was already pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sync stages s1, s2 and history s3 = 0.
  - pending = 0, irq_valid = 0, irq_code = 0, dropped = 0, state = IDLE.
- Synchroniser and edge detect, per bit:
  - s1 <= irq_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3.
  - A line already high at reset release gives one event, because s3 resets to 0.
- Pending update each clk:
  - pending <= (pending & ~clr) | rise.
  - clr has exactly one bit set (irq_code) when state = PRESENT and irq_ack = 1; otherwise clr = 0.
  - Set wins over clear: an edge on the acknowledged source in the same cycle leaves its bit at 1, with no dropped pulse.
- dropped <= |(rise & pending & ~clr), registered, high for one cycle.
- Latency: irq_in first sampled high at edge k gives pending set at edge k+2 and irq_valid = 1 at edge k+3, provided state = IDLE.
- Candidate vector: cand = pending & ~mask. Selection is a pure priority pick, lowest set index.
- State machine:
  - IDLE: irq_valid = 0.
    - If cand != 0: irq_code <= lowest set index of cand, irq_valid <= 1, go to PRESENT.
    - Else stay; irq_code keeps its last value.
    - irq_ack is ignored in IDLE.
  - PRESENT: irq_valid = 1 and irq_code frozen, even if mask, pending or higher-priority sources change.
    - If irq_ack = 1: clear pending[irq_code], irq_valid <= 0, go to IDLE.
    - Else hold.
- Throughput: at least one IDLE cycle between grants, so at most one grant per 2 cycles.
- Back-to-back: the next selection happens in IDLE using the updated pending register.
- Masking the presented source while in PRESENT does not withdraw it; ack still clears it.
- A masked pending source stays pending and is presented after it is unmasked.
- Ack held high continuously: a grant every 2 cycles until cand = 0.
- Reset mid-handshake: everything returns to reset values immediately and all pending events are lost.

Test Plan:
- Reset release with irq_in = 0: pending = 0, irq_valid = 0, irq_code = 0 → raise irq_in[5] at edge 0 → pending = 8'h20 at edge 2, irq_valid = 1 with irq_code = 5 at edge 3.
- Priority: irq_in[6] and irq_in[2] rise in the same cycle → code 2 first; ack → code 6 two cycles later; ack → pending = 0, irq_valid stays 0.
- Mask: pending = 8'h09 with mask = 8'h01 → code 3; ack; clear mask → code 0 presented.
- Stability: while presenting code 4, irq_in[1] rises → irq_code stays 4 until ack; code 1 is presented two cycles after the ack.
- Drop and overlap:
  - Second edge on irq_in[7] while pending[7] = 1 and not acked → dropped = 1 for exactly one cycle; pending[7] stays 1.
  - Edge on 7 in the same cycle as its ack → pending[7] = 1 and dropped = 0.
- Async reset asserted mid-cycle in PRESENT → irq_valid = 0, pending = 0 immediately; irq_in held high through reset → one new event after release.
